bcd_entry_scroller: RTL and testbench
=====================================

Name: bcd_entry_scroller

Overview:
- Builds the 11-digit BCD operand/result register from single-cycle keypad events: digit entry, backspace and clear.
- Generates the 3-bit window-offset count that selects which 6 digits are shown on the display.
- It is the writer/controller side of the display window selector: its bcd_out and count feed that selector's BCD input and count input directly.
- Sits between the debounced keypad decoder and the output unit.

Parameters:
- DIGITS, 11, number of BCD digits held; register width is 4*DIGITS.
- WINDOW, 6, number of digits visible on the display at once.
- CNT_W, 3, width of the window-offset count; must hold DIGITS-WINDOW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  one-cycle pulse; key_code holds a digit to enter.
- key_code  input  4  digit value; 0-9 valid, 10-15 ignored.
- key_back  input  1  one-cycle pulse; delete the least-significant digit.
- key_clear  input  1  one-cycle pulse; clear all digits.
- scroll_left  input  1  one-cycle pulse; move the window toward the more-significant digits.
- scroll_right  input  1  one-cycle pulse; move the window toward the less-significant digits.
- bcd_out  output  44  BCD value; digit 0 (least significant) in bits [3:0].
- count  output  CNT_W  window offset; 0 shows digits 0-5, k shows digits k to k+5.
- digit_count  output  4  number of significant digits entered, 0-11.
- full  output  1  high when digit_count == DIGITS.
- overflow  output  1  one-cycle pulse when a digit entry is rejected because full is high.

Behaviour:
- Reset (async, rst_n low): bcd_out=0, count=0, digit_count=0, full=0, overflow=0. Reset may occur mid-sequence and takes effect immediately. The first edit is accepted on the first rising edge after rst_n deasserts.
- All outputs are registered. Every event is reflected on the outputs one clock after the event cycle.
- Per-cycle edit priority: key_clear > key_back > key_valid. Only the highest-priority asserted edit is performed.
- Clear:
  - bcd_out=0, digit_count=0, count=0.
  - overflow stays 0 even if key_valid is also asserted in the same cycle.
- Backspace:
  - If digit_count==0: no change.
  - Otherwise: bcd_out shifts right by 4 with the top nibble filled with 0, digit_count decrements, count=0.
- Digit entry (key_valid with key_code <= 9):
  - If key_code > 9: the event is ignored entirely; no state change and no overflow.
  - If full: bcd_out and digit_count are unchanged, overflow pulses high for exactly one cycle, count is unchanged.
  - Else if digit_count==0 and key_code==0 (leading zero): bcd_out stays 0, digit_count stays 0, count=0.
  - Else: bcd_out = {bcd_out[39:0], key_code}, digit_count increments, count=0.
- full = (digit_count == DIGITS), updated in the same cycle as digit_count.
- Scroll limit: max_off = (digit_count > WINDOW) ? digit_count - WINDOW : 0. Range is 0..5 for the defaults.
- Scroll rules:
  - Scroll is evaluated only in cycles with no accepted edit. Any edit that changes state, or any rejected or ignored key event in the same cycle, suppresses scroll that cycle.
  - scroll_left alone: count increments if count < max_off, otherwise it holds (saturates; no wrap).
  - scroll_right alone: count decrements if count > 0, otherwise it holds.
  - scroll_left and scroll_right together: no change.
- Invariant: count <= max_off at all times. Every edit forces count to 0, so a backspace cannot leave count out of range.
- overflow is 0 in every cycle except a rejected-entry cycle. It must not stretch if rejected entries arrive on consecutive cycles; each such cycle pulses independently, so overflow stays high across those cycles.
- No internal FSM beyond the registers above; there is no combinational path from any input to any output.

Test Plan:
- Reset then key digits 1,2,3 -> bcd_out=0x123, digit_count=3, count=0, full=0; scroll_left -> count stays 0 (max_off=0).
- Key 0,0,7 from empty -> bcd_out=0x7, digit_count=1; then 10 and 15 on key_code -> no change.
- Enter 1..9,0,1 (11 digits) -> bcd_out=0x12345678901, full=1; 12th digit 5 -> bcd_out unchanged, overflow high exactly one cycle; scroll_left x7 -> count saturates at 5; scroll_right x6 -> count saturates at 0.
- With 11 digits and count=5: key_back -> bcd_out=0x1234567890, digit_count=10, full=0, count=0; key_back and key_valid(3) together -> only backspace (0x123456789).
- key_clear with key_valid(4) and scroll_left in the same cycle -> all zero, overflow=0, count=0; key_back on empty -> no change.
- Assert rst_n low mid-entry with count=3 -> all outputs 0 immediately (asynchronously); scroll_left and scroll_right together at 8 digits -> count unchanged.

Source files
------------

// File: rtl/bcd_entry_scroller.sv
// Keypad-driven BCD entry register with backspace/clear and a saturating
// display-window offset for the downstream 6-digit window selector.
module bcd_entry_scroller #(
    parameter int unsigned DIGITS = 11,
    parameter int unsigned WINDOW = 6,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic                  key_back,
    input  logic                  key_clear,
    input  logic                  scroll_left,
    input  logic                  scroll_right,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [CNT_W-1:0]      count,
    output logic [3:0]            digit_count,
    output logic                  full,
    output logic                  overflow
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0]     bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] off_q, off_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;

    logic             digit_ok;
    logic             key_event;
    logic [CNT_W-1:0] max_off;

    assign digit_ok  = (key_code <= 4'd9);
    // Any key activity, even ignored or rejected, blocks scrolling that cycle.
    assign key_event = key_clear | key_back | key_valid;

    always_comb begin
        max_off = '0;
        if (cnt_q > 4'(WINDOW)) begin
            max_off = CNT_W'(cnt_q - 4'(WINDOW));
        end
    end

    always_comb begin
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        off_d = off_q;
        ovf_d = 1'b0;

        if (key_clear) begin
            bcd_d = '0;
            cnt_d = '0;
            off_d = '0;
        end else if (key_back) begin
            if (cnt_q != 4'd0) begin
                bcd_d = {4'b0000, bcd_q[W-1:4]};
                cnt_d = cnt_q - 4'd1;
                off_d = '0;
            end
        end else if (key_valid) begin
            if (digit_ok) begin
                if (full_q) begin
                    ovf_d = 1'b1;
                end else if (cnt_q == 4'd0 && key_code == 4'd0) begin
                    off_d = '0;
                end else begin
                    bcd_d = {bcd_q[W-5:0], key_code};
                    cnt_d = cnt_q + 4'd1;
                    off_d = '0;
                end
            end
        end else if (!key_event) begin
            if (scroll_left && !scroll_right && off_q < max_off) begin
                off_d = off_q + 1'b1;
            end else if (scroll_right && !scroll_left && off_q != '0) begin
                off_d = off_q - 1'b1;
            end
        end

        full_d = (cnt_d == 4'(DIGITS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            cnt_q  <= '0;
            off_q  <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            off_q  <= off_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_count = cnt_q;
    assign count       = off_q;
    assign full        = full_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_bcd_entry_scroller.sv
// Self-checking bench: directed scenarios plus random keypad traffic compared
// against a digit-list reference model.
module tb_bcd_entry_scroller;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_back;
    logic        key_clear;
    logic        scroll_left;
    logic        scroll_right;
    logic [43:0] bcd_out;
    logic [2:0]  count;
    logic [3:0]  digit_count;
    logic        full;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: digits kept least-significant first.
    int m_digits[$];
    int m_off;
    bit m_ovf;

    bcd_entry_scroller #(.DIGITS(11), .WINDOW(6), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_back     (key_back),
        .key_clear    (key_clear),
        .scroll_left  (scroll_left),
        .scroll_right (scroll_right),
        .bcd_out      (bcd_out),
        .count        (count),
        .digit_count  (digit_count),
        .full         (full),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_bcd();
        logic [63:0] v;
        v = '0;
        foreach (m_digits[i]) v = v + (64'(m_digits[i]) << (4 * i));
        return v;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_off = 0;
        m_ovf = 0;
    endtask

    task automatic model_step(input bit clr, input bit bk, input bit vld, input int code,
                              input bit sl, input bit sr);
        int max_off;
        m_ovf = 0;
        if (clr) begin
            m_digits.delete();
            m_off = 0;
        end else if (bk) begin
            if (m_digits.size() > 0) begin
                void'(m_digits.pop_front());
                m_off = 0;
            end
        end else if (vld) begin
            if (code <= 9) begin
                if (m_digits.size() == 11) m_ovf = 1;
                else if (m_digits.size() == 0 && code == 0) m_off = 0;
                else begin
                    m_digits.push_front(code);
                    m_off = 0;
                end
            end
        end else begin
            max_off = (m_digits.size() > 6) ? m_digits.size() - 6 : 0;
            if (sl && !sr && m_off < max_off) m_off++;
            else if (sr && !sl && m_off > 0) m_off--;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".bcd"},         64'(bcd_out),     model_bcd());
        check({tag, ".digit_count"}, 64'(digit_count), 64'(m_digits.size()));
        check({tag, ".count"},       64'(count),       64'(m_off));
        check({tag, ".full"},        64'(full),        64'(m_digits.size() == 11));
        check({tag, ".overflow"},    64'(overflow),    64'(m_ovf));
    endtask

    task automatic apply(input string tag, input bit clr, input bit bk, input bit vld,
                         input logic [3:0] code, input bit sl, input bit sr);
        key_clear    = clr;
        key_back     = bk;
        key_valid    = vld;
        key_code     = code;
        scroll_left  = sl;
        scroll_right = sr;
        @(posedge clk);
        #1;
        key_clear    = 1'b0;
        key_back     = 1'b0;
        key_valid    = 1'b0;
        key_code     = 4'd0;
        scroll_left  = 1'b0;
        scroll_right = 1'b0;
        model_step(clr, bk, vld, int'(code), sl, sr);
        check_all(tag);
    endtask

    task automatic key(input string tag, input logic [3:0] code);
        apply(tag, 0, 0, 1, code, 0, 0);
    endtask

    initial begin
        logic [3:0] seq [11];
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};

        rst_n = 1'b0;
        key_valid = 1'b0; key_code = 4'd0; key_back = 1'b0;
        key_clear = 1'b0; scroll_left = 1'b0; scroll_right = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        key("d1", 4'd1); key("d2", 4'd2); key("d3", 4'd3);
        check("tp1_bcd", 64'(bcd_out), 64'h123);
        apply("tp1_scroll", 0, 0, 0, 4'd0, 1, 0);
        check("tp1_count", 64'(count), 64'd0);

        apply("clr", 1, 0, 0, 4'd0, 0, 0);
        key("z0", 4'd0); key("z1", 4'd0); key("d7", 4'd7);
        check("tp2_bcd", 64'(bcd_out), 64'h7);
        key("k10", 4'd10); key("k15", 4'd15);
        check("tp2_ign", 64'(bcd_out), 64'h7);

        apply("clr2", 1, 0, 0, 4'd0, 0, 0);
        for (int i = 0; i < 11; i++) key("fill", seq[i]);
        check("tp3_bcd", 64'(bcd_out), 64'h12345678901);
        check("tp3_full", 64'(full), 64'd1);
        key("ovf", 4'd5);
        check("tp3_ovf", 64'(overflow), 64'd1);
        apply("ovf_end", 0, 0, 0, 4'd0, 0, 0);
        check("tp3_ovf_one", 64'(overflow), 64'd0);
        key("ovf_a", 4'd5); key("ovf_b", 4'd6);
        check("tp3_ovf_back2back", 64'(overflow), 64'd1);
        for (int i = 0; i < 7; i++) apply("left", 0, 0, 0, 4'd0, 1, 0);
        check("tp3_sat_hi", 64'(count), 64'd5);
        for (int i = 0; i < 6; i++) apply("right", 0, 0, 0, 4'd0, 0, 1);
        check("tp3_sat_lo", 64'(count), 64'd0);

        for (int i = 0; i < 5; i++) apply("left5", 0, 0, 0, 4'd0, 1, 0);
        apply("back", 0, 1, 0, 4'd0, 0, 0);
        check("tp4_bcd", 64'(bcd_out), 64'h1234567890);
        check("tp4_count", 64'(count), 64'd0);
        apply("back_vld", 0, 1, 1, 4'd3, 0, 0);
        check("tp4_bcd2", 64'(bcd_out), 64'h123456789);

        apply("clr_all", 1, 0, 1, 4'd4, 1, 0);
        check("tp5_bcd", 64'(bcd_out), 64'h0);
        apply("back_empty", 0, 1, 0, 4'd0, 0, 0);

        for (int i = 0; i < 9; i++) key("mid", seq[i]);
        for (int i = 0; i < 3; i++) apply("mleft", 0, 0, 0, 4'd0, 1, 0);
        check("tp6_count3", 64'(count), 64'd3);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) key("eight", seq[i]);
        apply("lr1", 0, 0, 0, 4'd0, 1, 0);
        apply("lr_both", 0, 0, 0, 4'd0, 1, 1);
        check("tp6_both", 64'(count), 64'd1);

        for (int i = 0; i < 3000; i++) begin
            apply("rand",
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 40,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 25);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
